// File: rtl/dmem_if.sv
// dmem_if: request/ready bundle between the load/store stage and dmem_ctrl.
// parity_err exists only when DMEM_PARITY_EN is defined.
interface dmem_if #(
  parameter int ADDR_W = 12
) ();
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       d_in;
  logic              ready;
  logic [31:0]       rdata;
  logic              misalign;
  logic              busy;
`ifdef DMEM_PARITY_EN
  logic              parity_err;

  modport master (
    output req, we, size, sign_ext, addr, d_in,
    input  ready, rdata, misalign, busy, parity_err
  );
  modport slave (
    input  req, we, size, sign_ext, addr, d_in,
    output ready, rdata, misalign, busy, parity_err
  );
`else
  modport master (
    output req, we, size, sign_ext, addr, d_in,
    input  ready, rdata, misalign, busy
  );
  modport slave (
    input  req, we, size, sign_ext, addr, d_in,
    output ready, rdata, misalign, busy
  );
`endif
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte/half/word data memory, single access in flight, LAT-cycle latency.
// Define DMEM_PARITY_EN for per-byte even parity and a parity_err pulse on loads.
module dmem_ctrl #(
  parameter int    ADDR_W    = 12,
  parameter int    LAT       = 1,
  parameter string INIT_FILE = ""
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

  localparam int         DEPTH  = 2 ** (ADDR_W - 2);
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sx;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_din;
  logic              r_bad;
  logic              r_ready;
  logic [31:0]       r_rdata;
  logic              r_mis;
  logic              r_busy;

  logic [31:0] r_mem [DEPTH];
`ifdef DMEM_PARITY_EN
  logic [3:0]  r_par [DEPTH];
  logic        r_perr;
  logic [3:0]  w_pbad;
  logic        w_perr;
`endif

  logic              w_idle;
  logic              w_acc;
  logic              w_to_resp;
  logic              w_bad_in;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_size;
  logic              w_sx;
  logic              w_we;
  logic              w_bad;
  logic [31:0]       w_word;
  logic [31:0]       w_sh;
  logic [31:0]       w_ld;
  logic [31:0]       w_rd_next;
  logic [3:0]        w_mask;
  logic [31:0]       w_wdata;
  logic              w_wr;

  assign w_idle    = (r_state == S_IDLE);
  assign w_acc     = w_idle && bus.req;
  assign w_to_resp = (w_acc && (LAT_M1 == 4'd0)) ||
                     ((r_state == S_WAIT) && (r_cnt == 4'd1));

  assign w_bad_in = (bus.size == 2'b11) ||
                    ((bus.size == 2'b01) && bus.addr[0]) ||
                    ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));

  // With LAT=1 the response is built on the acceptance edge from the live bus.
  assign w_addr = w_idle ? bus.addr     : r_addr;
  assign w_size = w_idle ? bus.size     : r_size;
  assign w_sx   = w_idle ? bus.sign_ext : r_sx;
  assign w_we   = w_idle ? bus.we       : r_we;
  assign w_bad  = w_idle ? w_bad_in     : r_bad;

  assign w_word = r_mem[w_addr[ADDR_W-1:2]];
  assign w_sh   = w_word >> {w_addr[1:0], 3'b000};

  always_comb begin
    w_ld = w_sh;
    unique case (w_size)
      2'b00:   w_ld = {{24{w_sx & w_sh[7]}}, w_sh[7:0]};
      2'b01:   w_ld = {{16{w_sx & w_sh[15]}}, w_sh[15:0]};
      default: w_ld = w_sh;
    endcase
  end

  assign w_rd_next = (w_bad || w_we) ? 32'd0 : w_ld;

  always_comb begin
    w_mask = 4'b1111;
    unique case (w_size)
      2'b00:   w_mask = 4'b0001 << w_addr[1:0];
      2'b01:   w_mask = w_addr[1] ? 4'b1100 : 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  always_comb begin
    w_wdata = r_din;
    unique case (r_size)
      2'b00:   w_wdata = {4{r_din[7:0]}};
      2'b01:   w_wdata = {2{r_din[15:0]}};
      default: w_wdata = r_din;
    endcase
  end

  assign w_wr = (r_state == S_RESP) && r_we && !r_bad && !rst;

`ifdef DMEM_PARITY_EN
  always_comb begin
    w_pbad = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      w_pbad[k] = (^w_word[8*k +: 8]) != r_par[w_addr[ADDR_W-1:2]][k];
    end
  end
  assign w_perr = |(w_pbad & w_mask) && !w_we && !w_bad;
`endif

  // Storage is not reset; the write lands on the edge that ends RESP.
  always @(posedge clk) begin
    if (w_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (w_mask[k]) begin
          r_mem[r_addr[ADDR_W-1:2]][8*k +: 8] <= w_wdata[8*k +: 8];
`ifdef DMEM_PARITY_EN
          r_par[r_addr[ADDR_W-1:2]][k] <= ^w_wdata[8*k +: 8];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_sx    <= 1'b0;
      r_addr  <= '0;
      r_din   <= 32'd0;
      r_bad   <= 1'b0;
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
      r_mis   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef DMEM_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_size  <= bus.size;
            r_sx    <= bus.sign_ext;
            r_addr  <= bus.addr;
            r_din   <= bus.d_in;
            r_bad   <= w_bad_in;
            r_cnt   <= LAT_M1;
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_mis   <= 1'b0;
`ifdef DMEM_PARITY_EN
          r_perr  <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_to_resp) begin
        r_state <= S_RESP;
        r_ready <= 1'b1;
        r_mis   <= w_bad;
        r_rdata <= w_rd_next;
`ifdef DMEM_PARITY_EN
        r_perr  <= w_perr;
`endif
      end
    end
  end

  assign bus.ready    = r_ready;
  assign bus.rdata    = r_rdata;
  assign bus.misalign = r_mis;
  assign bus.busy     = r_busy;
`ifdef DMEM_PARITY_EN
  assign bus.parity_err = r_perr;
`endif

endmodule
